// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-stage load/store unit: access sizes, FSM states and
// the default bus timeout.
package mem_access_pkg;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    localparam int unsigned TimeoutDefault = 255;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
        if (size == SizeByte) begin
            return 1'b0;
        end else if (size == SizeHalf) begin
            return addr_lo[0];
        end
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/mod_load_align.sv
// Combinational lane logic: byte enables, store-data replication and load lane
// extraction with sign/zero extension.
module mod_load_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        unsigned_ld,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = 8'(rdata >> {addr_lo, 3'b000});
    assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        case (size)
            SizeByte: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = unsigned_ld ? {24'h0, byte_lane}
                                        : {{24{byte_lane[7]}}, byte_lane};
            end
            SizeHalf: begin
                // addr_lo[0] is ignored; the trap (if built) catches it upstream.
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = unsigned_ld ? {16'h0, half_lane}
                                        : {{16{half_lane[15]}}, half_lane};
            end
            default: begin
                be        = 4'b1111;
                wdata     = store_data;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mod_mem_access_unit.sv
// Memory-stage load/store unit: single-outstanding req/ack data-bus master with load
// alignment and pipeline stall. Optional misalignment trap: MEM_MISALIGN_TRAP_EN.
module mod_mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] ext_mem_data,
    output logic        load_valid,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q;
    logic        we_q, uns_q, load_valid_q, bus_err_q;
    logic [1:0]  size_q, lo_q;
    logic [31:0] bus_addr_q, wdata_q, ext_q;
    logic [3:0]  be_q;

    logic        req_one, req_both, trap_req, timeout_hit, in_idle;
    logic [1:0]  al_size, al_lo;
    logic        al_uns;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;

    assign in_idle  = state_q == StIdle;
    assign req_one  = mem_read ^ mem_write;
    assign req_both = mem_read & mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap_req   = req_one & is_misaligned(size, addr[1:0]);
    assign misaligned = mis_q;
`else
    assign trap_req = 1'b0;
`endif

    // Fires on the TIMEOUT-th BUSY cycle without an ack.
    assign timeout_hit = (32'(cnt_q) + 32'd1) >= TIMEOUT;

    // Live request while launching; the captured request while waiting for data.
    assign al_size = in_idle ? size        : size_q;
    assign al_lo   = in_idle ? addr[1:0]   : lo_q;
    assign al_uns  = in_idle ? unsigned_ld : uns_q;

    mod_load_align u_load_align (
        .size        (al_size),
        .addr_lo     (al_lo),
        .unsigned_ld (al_uns),
        .store_data  (store_data),
        .rdata       (bus_rdata),
        .be          (al_be),
        .wdata       (al_wdata),
        .load_data   (al_load)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_both || trap_req) begin
                    state_d = StDone;
                end else if (req_one) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (bus_ack || timeout_hit) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= '0;
            lo_q         <= '0;
            bus_addr_q   <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            ext_q        <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q        <= 1'b0;
`endif
        end else begin
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q        <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (req_both) begin
                        bus_err_q <= 1'b1;
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    if (!req_both && trap_req) begin
                        mis_q <= 1'b1;
                    end
`endif
                    if (state_d == StBusy) begin
                        cnt_q      <= '0;
                        we_q       <= mem_write;
                        uns_q      <= unsigned_ld;
                        size_q     <= size;
                        lo_q       <= addr[1:0];
                        bus_addr_q <= {addr[31:2], 2'b00};
                        be_q       <= al_be;
                        wdata_q    <= al_wdata;
                    end
                end
                StBusy: begin
                    if (cnt_q != 8'hff) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (bus_ack) begin
                        if (!we_q) begin
                            ext_q        <= al_load;
                            load_valid_q <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        ext_q     <= '0;
                        bus_err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall        = (in_idle & (mem_read | mem_write)) | (state_q == StBusy);
    assign bus_req      = state_q == StBusy;
    assign bus_we       = we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_be       = be_q;
    assign bus_wdata    = wdata_q;
    assign ext_mem_data = ext_q;
    assign load_valid   = load_valid_q;
    assign bus_err      = bus_err_q;

endmodule
